// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: R-type funct codes used by the HI/LO path
// and the state encoding of the multi-cycle divider.
package mips_pkg;

    localparam logic [5:0] FUNCT_MFHI = 6'd16;
    localparam logic [5:0] FUNCT_MFLO = 6'd18;
    localparam logic [5:0] FUNCT_DIVU = 6'd27;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module divu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             take;

    // Compare on WIDTH+1 bits; when the subtraction is taken the true
    // difference is below 2^WIDTH, so a WIDTH-bit subtract is exact.
    always_comb begin
        rem_sh   = {rem, q[WIDTH-1]};
        take     = (rem_sh >= {1'b0, divisor});
        diff     = rem_sh[WIDTH-1:0] - divisor;
        rem_next = take ? diff : rem_sh[WIDTH-1:0];
        q_next   = {q[WIDTH-2:0], take};
    end

endmodule

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider owning the architectural HI/LO registers.
// HI receives the remainder, LO the quotient; busy stalls the pipeline.
// Optional macro DIVU_FAST_PATH_EN resolves divide-by-zero and
// dividend<divisor on the launch edge without entering RUN.
module divu_hilo_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    div_state_e       state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    divu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .q       (quo_q),
        .divisor (div_q),
        .rem_next(rem_nxt),
        .q_next  (quo_nxt)
    );

    // Divider FSM; all outputs are registered. DONE accepts a new start
    // exactly like IDLE so back-to-back DIVUs lose no cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (start) begin
`ifdef DIVU_FAST_PATH_EN
                        if (divisor == '0) begin
                            lo_q    <= '1;
                            hi_q    <= dividend;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (dividend < divisor) begin
                            lo_q    <= '0;
                            hi_q    <= dividend;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            quo_q   <= dividend;
                            rem_q   <= '0;
                            div_q   <= divisor;
                            cnt_q   <= CNT_W'(WIDTH);
                            busy_q  <= 1'b1;
                            state_q <= StRun;
                        end
`else
                        quo_q   <= dividend;
                        rem_q   <= '0;
                        div_q   <= divisor;
                        cnt_q   <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= StRun;
`endif
                    end
                end
                StRun: begin
                    // start is deliberately ignored here
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= rem_nxt;
                        lo_q    <= quo_nxt;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs straight to the pipeline.
    always_comb begin
        busy = busy_q;
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Self-checking bench for divu_hilo_unit: directed scenarios plus randomized
// operands against a plain '/' and '%' reference model.
module tb_divu_hilo_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          errors;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;

    divu_hilo_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dividend(dividend),
        .divisor (divisor),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Launch a/b, optionally poke a stray start at cycle inject_at, and check
    // latency, busy count, hold behaviour and final HI/LO.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                         input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic        fast;
        logic        seen;
        int          lat;
        int          busy_cnt;
        model(a, b, eq, er);
        fast = 1'b0;
`ifdef DIVU_FAST_PATH_EN
        fast = (b == 32'd0) || (a < b);
`endif
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat <= 40) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                checks++;
                if (hi !== hold_hi || lo !== hold_lo) begin
                    errors++;
                    $display("FAIL %s hold: hi=%h lo=%h expected hi=%h lo=%h at cycle %0d",
                             tag, hi, lo, hold_hi, hold_lo, lat);
                end
                if (lat == inject_at) begin
                    start    = 1'b1;
                    dividend = 32'd50;
                    divisor  = 32'd3;
                end
                tick();
                start = 1'b0;
                lat++;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: done=0 after %0d cycles, expected a done pulse", tag, lat);
        end else begin
            checks++;
            if (lat != (fast ? 0 : 32)) begin
                errors++;
                $display("FAIL %s latency: %0d cycles expected %0d", tag, lat, fast ? 0 : 32);
            end
            checks++;
            if (busy_cnt != (fast ? 0 : 32) || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy: %0d busy cycles (busy now %b) expected %0d and 0",
                         tag, busy_cnt, busy, fast ? 0 : 32);
            end
            checks++;
            if (hi !== er || lo !== eq) begin
                errors++;
                $display("FAIL %s result %h/%h: hi=%h lo=%h expected hi=%h lo=%h",
                         tag, a, b, hi, lo, er, eq);
            end
        end
        hold_hi = er;
        hold_lo = eq;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b hi=%h lo=%h expected all 0",
                     tag, busy, done, hi, lo);
        end
    endtask

    task automatic check_done_drops(input string tag);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: done=%b busy=%b expected 0 and 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        hold_hi  = '0;
        hold_lo  = '0;
        #1;
        check_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_zero("reset_release");
    endtask

    task automatic test_basic();
        do_op(32'd100, 32'd7, -1, "div_100_7");
        check_done_drops("div_100_7");
    endtask

    task automatic test_back_to_back();
        do_op(32'hFFFF_FFFF, 32'd1, -1, "b2b_first");
        do_op(32'h8000_0000, 32'h8000_0000, -1, "b2b_second");
        check_done_drops("b2b_second");
    endtask

    task automatic test_div_zero();
        do_op(32'd5, 32'd0, -1, "div_zero");
        check_done_drops("div_zero");
        do_op(32'd3, 32'd9, -1, "small_dividend");
        check_done_drops("small_dividend");
    endtask

    task automatic test_start_ignored();
        do_op(32'd1000, 32'd10, 10, "start_in_run");
        check_done_drops("start_in_run");
    endtask

    task automatic test_reset_mid_run();
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        tick();
        start = 1'b0;
        repeat (14) tick();
        #2;
        rst = 1'b0;
        #1;
        check_zero("reset_mid_run");
        tick();
        rst = 1'b1;
        hold_hi = '0;
        hold_lo = '0;
        repeat (3) tick();
        check_zero("reset_mid_run_after");
        do_op(32'd100, 32'd7, -1, "after_reset");
        check_done_drops("after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) b = a;
            do_op(a, b, -1, "random");
            if ($urandom_range(0, 1) == 0) check_done_drops("random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
